// File: rtl/serial_frame_receiver.sv
// Serial byte receiver: 2-flop synchroniser, mid-bit sampling FSM,
// valid/ready byte output with frame-error and overrun pulses.
module serial_frame_receiver #(
    parameter int FRAME_WIDTH  = 10,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_rx,
    input  logic                   i_ready,
    output logic [FRAME_WIDTH-3:0] o_data,
    output logic                   o_valid,
    output logic                   o_frame_err,
    output logic                   o_overrun,
    output logic                   o_busy
);

    localparam int DATA_BITS = FRAME_WIDTH - 2;
    localparam int TW        = $clog2(CLKS_PER_BIT);
    localparam int BW        = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] HALF_M1  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           sync_q;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;

    logic rx_s;
    logic tick;

    assign rx_s = sync_q[1];
    assign tick = (tick_q == '0);

    always_comb begin
        state_d = state_q;
        tick_d  = tick ? FULL_M1 : tick_q - 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q & ~i_ready;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    tick_d  = HALF_M1;
                end
            end
            START: begin
                if (tick) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (!rx_s) begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end else begin
                        state_d = IDLE;
                        // A byte accepted on this edge frees the slot for the new one
                        if (!valid_q || i_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end
                end
            end
            WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], i_rx};
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_overrun   = ovr_q;
    assign o_busy      = (state_q != IDLE);

endmodule
